// File: rtl/irq_cause_queue.sv
// Interrupt-cause FIFO: captures rising edges of io_irq with their cause word,
// presents them over a valid/ready port and counts events dropped while full.
module irq_cause_queue #(
    parameter int CAUSE_W = 6,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     io_irq,
    input  logic [CAUSE_W-1:0]       io_irq_cause,
    input  logic                     io_deq_ready,
    output logic                     io_deq_valid,
    output logic [CAUSE_W-1:0]       io_deq_bits,
    output logic [$clog2(DEPTH):0]   io_count,
    output logic                     io_overflow,
    output logic [CNT_W-1:0]         io_drop_cnt,
    input  logic                     io_clr_overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [CAUSE_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W:0]     count;
    logic               irq_prev;
    logic               overflow;
    logic [CNT_W-1:0]   drop_cnt;

    logic evt;
    logic full;
    logic deq_fire;
    logic enq_fire;
    logic drop;

    always_comb begin
        evt      = io_irq & ~irq_prev;
        full     = (count == FULL_COUNT);
        deq_fire = io_deq_valid & io_deq_ready;
        // A full queue still accepts an event when the head pops in the same cycle.
        enq_fire = evt & (~full | deq_fire);
        drop     = evt & full & ~deq_fire;
    end

    assign io_deq_valid = (count != '0);
    assign io_deq_bits  = io_deq_valid ? mem[rd_ptr] : '0;
    assign io_count     = count;
    assign io_overflow  = overflow;
    assign io_drop_cnt  = drop_cnt;

    // NOTE: storage has no reset; every entry is written before it can be read.
    always_ff @(posedge clk) begin
        if (!reset && enq_fire) begin
            mem[wr_ptr] <= io_irq_cause;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            irq_prev <= 1'b0;
        end else begin
            irq_prev <= io_irq;
            if (enq_fire) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (deq_fire) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (enq_fire && !deq_fire) begin
                count <= count + (PTR_W + 1)'(1);
            end else if (!enq_fire && deq_fire) begin
                count <= count - (PTR_W + 1)'(1);
            end
        end
    end

    // A drop in the same cycle as a clear wins, restarting the tally at one.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (io_clr_overflow) begin
                drop_cnt <= CNT_W'(1);
            end else if (!(&drop_cnt)) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end
        end else if (io_clr_overflow) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_irq_cause_queue.sv
// Self-checking bench for irq_cause_queue: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_irq_cause_queue;

    localparam int DEPTH   = 4;
    localparam int CNT_MAX = 255;

    logic       clk = 1'b0;
    logic       reset;
    logic       io_irq;
    logic [5:0] io_irq_cause;
    logic       io_deq_ready;
    logic       io_deq_valid;
    logic [5:0] io_deq_bits;
    logic [2:0] io_count;
    logic       io_overflow;
    logic [7:0] io_drop_cnt;
    logic       io_clr_overflow;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [5:0] m_q[$];
    logic       m_prev = 1'b0;
    logic       m_ovf  = 1'b0;
    int         m_drops = 0;

    irq_cause_queue dut (
        .clk             (clk),
        .reset           (reset),
        .io_irq          (io_irq),
        .io_irq_cause    (io_irq_cause),
        .io_deq_ready    (io_deq_ready),
        .io_deq_valid    (io_deq_valid),
        .io_deq_bits     (io_deq_bits),
        .io_count        (io_count),
        .io_overflow     (io_overflow),
        .io_drop_cnt     (io_drop_cnt),
        .io_clr_overflow (io_clr_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input logic rst, input logic irq, input logic [5:0] cause,
                                input logic rdy, input logic clr);
        logic evt;
        logic deq;
        if (rst) begin
            m_q.delete();
            m_prev  = 1'b0;
            m_ovf   = 1'b0;
            m_drops = 0;
        end else begin
            evt = irq && !m_prev;
            deq = rdy && (m_q.size() > 0);
            if (evt && m_q.size() == DEPTH && !deq) begin
                m_ovf   = 1'b1;
                m_drops = clr ? 1 : ((m_drops < CNT_MAX) ? m_drops + 1 : CNT_MAX);
            end else if (clr) begin
                m_ovf   = 1'b0;
                m_drops = 0;
            end
            if (deq) void'(m_q.pop_front());
            if (evt && (m_q.size() < DEPTH)) m_q.push_back(cause);
            m_prev = irq;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".count"}, 32'(io_count), 32'(m_q.size()));
        check({tag, ".valid"}, 32'(io_deq_valid), 32'(m_q.size() > 0));
        check({tag, ".bits"}, 32'(io_deq_bits), (m_q.size() > 0) ? 32'(m_q[0]) : 32'd0);
        check({tag, ".ovf"}, 32'(io_overflow), 32'(m_ovf));
        check({tag, ".drops"}, 32'(io_drop_cnt), 32'(m_drops));
    endtask

    // One clock: drive on the falling edge, update model at the rising edge, sample 1ns later.
    task automatic step(input string tag, input logic rst, input logic irq,
                        input logic [5:0] cause, input logic rdy, input logic clr);
        @(negedge clk);
        reset           = rst;
        io_irq          = irq;
        io_irq_cause    = cause;
        io_deq_ready    = rdy;
        io_clr_overflow = clr;
        @(posedge clk);
        model_update(rst, irq, cause, rdy, clr);
        #1;
        compare_all(tag);
    endtask

    initial begin
        reset = 1'b1; io_irq = 1'b0; io_irq_cause = '0; io_deq_ready = 1'b0; io_clr_overflow = 1'b0;

        // Reset state
        step("reset", 1, 0, 6'h00, 0, 0);
        step("reset", 1, 0, 6'h00, 0, 0);
        check("reset_count", 32'(io_count), 32'd0);

        // Basic single event then pop
        step("basic_enq", 0, 1, 6'h22, 0, 0);
        check("basic_valid", 32'(io_deq_valid), 32'd1);
        check("basic_bits", 32'(io_deq_bits), 32'h22);
        step("basic_deq", 0, 0, 6'h00, 1, 0);
        check("basic_empty_bits", 32'(io_deq_bits), 32'd0);
        step("empty_ready", 0, 0, 6'h00, 1, 0);

        // Level held high is one event; re-raise gives a second
        for (int i = 0; i < 10; i++) step("level_hold", 0, 1, 6'h22, 0, 0);
        check("level_one_entry", 32'(io_count), 32'd1);
        step("level_drop", 0, 0, 6'h00, 0, 0);
        step("level_reraise", 0, 1, 6'h22, 0, 0);
        check("level_two_entries", 32'(io_count), 32'd2);
        step("level_drain", 0, 0, 6'h00, 1, 0);
        step("level_drain", 0, 0, 6'h00, 1, 0);

        // Fill and overflow with 6 events
        for (int i = 1; i <= 6; i++) begin
            step("fill_hi", 0, 1, 6'(6'h20 + i), 0, 0);
            step("fill_lo", 0, 0, 6'h00, 0, 0);
        end
        check("fill_count", 32'(io_count), 32'd4);
        check("fill_ovf", 32'(io_overflow), 32'd1);
        check("fill_drops", 32'(io_drop_cnt), 32'd2);
        for (int i = 1; i <= 4; i++) begin
            check("fill_order", 32'(io_deq_bits), 32'(6'h20 + i));
            step("fill_drain", 0, 0, 6'h00, 1, 0);
        end
        step("clear", 0, 0, 6'h00, 0, 1);

        // Full queue with simultaneous enqueue and dequeue
        for (int i = 1; i <= 4; i++) begin
            step("full_hi", 0, 1, 6'(6'h30 + i), 0, 0);
            step("full_lo", 0, 0, 6'h00, 0, 0);
        end
        step("full_simul", 0, 1, 6'h3f, 1, 0);
        check("simul_count", 32'(io_count), 32'd4);
        check("simul_drops", 32'(io_drop_cnt), 32'd0);
        check("simul_head", 32'(io_deq_bits), 32'h32);
        for (int i = 0; i < 3; i++) step("simul_drain", 0, 0, 6'h00, 1, 0);
        check("simul_last", 32'(io_deq_bits), 32'h3f);
        step("simul_drain", 0, 0, 6'h00, 1, 0);

        // Wrap: 20 enqueue/dequeue pairs
        for (int i = 0; i < 20; i++) begin
            step("wrap_enq", 0, 1, 6'($urandom), 0, 0);
            step("wrap_deq", 0, 0, 6'h00, 1, 0);
        end

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            step("random", 0, 1'($urandom), 6'($urandom), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 15) == 0));
        end

        // Saturation: fill, then 300 drops
        while (io_count != 3'(DEPTH)) begin
            step("sat_fill_hi", 0, 1, 6'($urandom), 0, 0);
            step("sat_fill_lo", 0, 0, 6'h00, 0, 0);
        end
        step("sat_clear", 0, 0, 6'h00, 0, 1);
        for (int i = 0; i < 300; i++) begin
            step("sat_hi", 0, 1, 6'($urandom), 0, 0);
            step("sat_lo", 0, 0, 6'h00, 0, 0);
        end
        check("sat_drops", 32'(io_drop_cnt), 32'd255);
        step("clr_with_drop", 0, 1, 6'h11, 0, 1);
        check("clr_drop_ovf", 32'(io_overflow), 32'd1);
        check("clr_drop_cnt", 32'(io_drop_cnt), 32'd1);
        step("clr_alone", 0, 0, 6'h00, 0, 1);
        check("clr_alone_ovf", 32'(io_overflow), 32'd0);
        check("clr_alone_cnt", 32'(io_drop_cnt), 32'd0);

        // Reset mid-operation: 3 entries and overflow set
        step("mid_drop", 0, 1, 6'h12, 0, 0);
        step("mid_deq", 0, 0, 6'h00, 1, 0);
        check("mid_count3", 32'(io_count), 32'd3);
        check("mid_ovf", 32'(io_overflow), 32'd1);
        step("mid_reset", 1, 1, 6'h15, 0, 0);
        check("mid_reset_count", 32'(io_count), 32'd0);
        check("mid_reset_bits", 32'(io_deq_bits), 32'd0);
        step("post_reset", 0, 1, 6'h15, 0, 0);
        check("post_reset_count", 32'(io_count), 32'd1);
        check("post_reset_bits", 32'(io_deq_bits), 32'h15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
